sb_config_loader: RTL

- Sequences configuration of a switch-box / fabric scan chain (chained shift_reg config registers, each mux control bit one flop).
- Accepts configuration words from a host over a valid/ready stream, serialises them LSB-first onto the chain's scan input, and drives scan_en.
- Drives scan_en for exactly CHAIN_LENGTH shift cycles, then pulses done.
- Captures the bits returning from the chain's scan output as readback words, so the previous configuration can be checked.

---
 rtl/sb_config_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sb_config_loader.sv
// Scan-chain configuration loader for a switch-box / fabric config chain.
// Host words arrive on a valid/ready stream and are shifted onto the chain
// LSB-first. scan_en stays high for exactly CHAIN_LENGTH cycles per load.
// Bits coming back out of the chain are packed into readback words, so the
// configuration that was in the chain before this load can be inspected.
module sb_config_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  scan_data,
    output logic                  scan_en,
    input  logic                  scan_return,
    output logic                  rb_valid,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  busy,
    output logic                  done
);

    localparam int RB_CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [CNT_WIDTH-1:0] WORD_BITS_MAX = CNT_WIDTH'(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CHAIN_BITS    = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
    localparam logic [RB_CNT_W-1:0]  RB_LAST       = RB_CNT_W'(WORD_WIDTH - 1);
    localparam logic [RB_CNT_W-1:0]  RB_ONE        = RB_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                  state_q,     state_d;
    logic [WORD_WIDTH-1:0]   shift_buf_q, shift_buf_d;
    logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0]    word_bits_q, word_bits_d;
    logic [WORD_WIDTH-1:0]   rb_shift_q,  rb_shift_d;
    logic [RB_CNT_W-1:0]     rb_cnt_q,    rb_cnt_d;
    logic [WORD_WIDTH-1:0]   rb_data_q,   rb_data_d;
    logic                    rb_valid_q,  rb_valid_d;

    // Readback word including this cycle's returning bit at slot rb_cnt_q.
    logic [WORD_WIDTH-1:0]   rb_word;

    // Readback slot insert: each position either takes scan_return or keeps its old value.
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_rb_word
        assign rb_word[gi] = (rb_cnt_q == RB_CNT_W'(gi)) ? scan_return : rb_shift_q[gi];
    end

    // Outputs are either state decodes or registers, never input-dependent.
    assign in_ready  = (state_q == ST_WAIT_WORD);
    assign scan_en   = (state_q == ST_SHIFT);
    assign scan_data = (state_q == ST_SHIFT) & shift_buf_q[0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rb_valid  = rb_valid_q;
    assign rb_data   = rb_data_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_buf_q <= '0;
            remaining_q <= '0;
            word_bits_q <= '0;
            rb_shift_q  <= '0;
            rb_cnt_q    <= '0;
            rb_data_q   <= '0;
            rb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_buf_q <= shift_buf_d;
            remaining_q <= remaining_d;
            word_bits_q <= word_bits_d;
            rb_shift_q  <= rb_shift_d;
            rb_cnt_q    <= rb_cnt_d;
            rb_data_q   <= rb_data_d;
            rb_valid_q  <= rb_valid_d;
        end
    end

    // Next-state logic: word fetch, serialisation, bit counting and readback packing.
    always_comb begin
        state_d     = state_q;
        shift_buf_d = shift_buf_q;
        remaining_d = remaining_q;
        word_bits_d = word_bits_q;
        rb_shift_d  = rb_shift_q;
        rb_cnt_d    = rb_cnt_q;
        rb_data_d   = rb_data_q;
        rb_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WAIT_WORD;
                    remaining_d = CHAIN_BITS;
                end
            end

            ST_WAIT_WORD: begin
                if (in_valid) begin
                    shift_buf_d = in_data;
                    // The last word may be partial; its excess upper bits never leave the buffer.
                    word_bits_d = (remaining_q >= WORD_BITS_MAX) ? WORD_BITS_MAX : remaining_q;
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                shift_buf_d = shift_buf_q >> 1;
                remaining_d = remaining_q - CNT_ONE;
                word_bits_d = word_bits_q - CNT_ONE;
                if (word_bits_q == CNT_ONE) begin
                    state_d = (remaining_q == CNT_ONE) ? ST_DONE : ST_WAIT_WORD;
                end

                // A readback word closes when full or when the final chain bit arrives.
                if ((rb_cnt_q == RB_LAST) || (remaining_q == CNT_ONE)) begin
                    rb_data_d  = rb_word;
                    rb_valid_d = 1'b1;
                    rb_shift_d = '0;
                    rb_cnt_d   = '0;
                end else begin
                    rb_shift_d = rb_word;
                    rb_cnt_d   = rb_cnt_q + RB_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
